tug_of_war_field: RTL and testbench
===================================

TUG_OF_WAR_FIELD -- requirements
Module: tug_of_war_field

Interface
REQ-001 The module SHALL use one clock and a synchronous, active-high reset.
REQ-002 Parameter list: none; all constants come from the shared package.
REQ-003 clk  input  1  system clock, all state updates on posedge.
REQ-004 reset  input  1  synchronous active-high reset.
REQ-005 press  input  2  single-cycle press pulses from the key input processor; press[1] is player1 and press[0] is player2.
REQ-006 leds  output  9  one-hot playfield; leds[4] is centre, leds[8] is the player1 goal end, leds[0] is the player2 goal end.
REQ-007 hex1  output  7  active-low 7-segment pattern of player1 score (0-7).
REQ-008 hex2  output  7  active-low 7-segment pattern of player2 score (0-7).
REQ-009 winner  output  2  match winner: 2'b10 player1, 2'b01 player2, 2'b00 none yet.

Function
REQ-010 The FSM SHALL have states PLAY, P1WIN, P2WIN and DONE.
REQ-011 Position register pos SHALL be 4 bits wide, hold values 0-8, and leds SHALL equal one-hot(pos) in PLAY.
REQ-012 In PLAY, press=2'b10 with pos<8 SHALL set pos=pos+1 on the next posedge (1-cycle latency).
REQ-013 In PLAY, press=2'b01 with pos>0 SHALL set pos=pos-1 on the next posedge.
REQ-014 In PLAY, press=2'b11 (simultaneous) or 2'b00 SHALL leave pos unchanged.
REQ-015 In PLAY, press=2'b10 with pos=8 SHALL enter P1WIN and increment score1.
REQ-016 In PLAY, press=2'b01 with pos=0 SHALL enter P2WIN and increment score2.
REQ-017 Score counters SHALL be 3 bits wide and SHALL NOT wrap: the increment to 7 ends the match.
REQ-018 P1WIN/P2WIN SHALL last exactly one cycle with leds=9'b0, and presses during it SHALL be ignored.
REQ-019 From PxWIN, the block SHALL go to PLAY with pos=4 if the winner's score is below 7, otherwise to DONE.
REQ-020 In DONE, leds SHALL be 9'b0, winner SHALL hold the match winner, and all presses SHALL be ignored until reset.
REQ-021 winner SHALL be 2'b00 in every state except DONE.
REQ-022 hex1 and hex2 SHALL track the score registers combinationally (same cycle as the score update).
REQ-023 7-segment encoding SHALL be active-low gfedcba: 0=7'b1000000, 1=7'b1111001, 2=7'b0100100, 3=7'b0110000, 4=7'b0011001, 5=7'b0010010, 6=7'b0000010, 7=7'b1111000.

Reset
REQ-024 When reset is high at a posedge, the block SHALL set state=PLAY, pos=4, score1=0, score2=0, leds=9'b000010000, winner=2'b00 and hex1=hex2=7'b1000000.
REQ-025 Reset SHALL take priority over press in the same cycle, including mid-round, during PxWIN, and in DONE.
REQ-026 Before the first reset, output values are undefined and are not checked.

Structure
REQ-027 Package tow_pkg SHALL hold the state enum, NUM_LEDS=9, CENTER=4 and MAX_SCORE=7.
REQ-028 One sub-module, score_seg7 (3-bit score to 7-bit active-low pattern), SHALL be instantiated twice.
REQ-029 The block SHALL contain one always_ff for state, pos and scores, with next-state and output logic in always_comb.

Verification
REQ-030 Scenario: reset, then 4 cycles of press=2'b10 -> pos goes 5,6,7,8 one cycle after each pulse, and leds reaches 9'b100000000.
REQ-031 Scenario: from pos=8, press=2'b10 -> one cycle leds=0 with hex1=7'b1111001, then leds=9'b000010000.
REQ-032 Scenario: press=2'b11 for 3 cycles at pos=4 -> pos stays 4 and scores stay unchanged.
REQ-033 Scenario: player2 wins 7 rounds -> state DONE, winner=2'b01, hex2=7'b1111000, leds=0, and further presses have no effect.
REQ-034 Scenario: reset asserted at pos=6 with press=2'b10 in the same cycle -> pos=4 and scores=0 next cycle.
REQ-035 Scenario: press=2'b10 during a P1WIN cycle -> ignored; the next round starts at pos=4, not 5.

Source files
------------

// File: rtl/tow_pkg.sv
// Shared constants and state encoding for the tug-of-war playfield.
package tow_pkg;

  localparam int NUM_LEDS = 9;
  localparam logic [3:0] CENTER = 4'd4;
  localparam logic [3:0] POS_MAX = 4'(NUM_LEDS - 1);
  localparam logic [2:0] MAX_SCORE = 3'd7;

  typedef enum logic [1:0] {
    PLAY  = 2'd0,
    P1WIN = 2'd1,
    P2WIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [1:0] WIN_P1 = 2'b10;
  localparam logic [1:0] WIN_P2 = 2'b01;
  localparam logic [1:0] WIN_NONE = 2'b00;

endpackage

// File: rtl/score_seg7.sv
// Score (0-7) to active-low gfedcba seven-segment pattern.
module score_seg7 (
  input  logic [2:0] score,
  output logic [6:0] seg
);

  always_comb begin
    seg = 7'b1111111;
    case (score)
      3'd0: seg = 7'b1000000;
      3'd1: seg = 7'b1111001;
      3'd2: seg = 7'b0100100;
      3'd3: seg = 7'b0110000;
      3'd4: seg = 7'b0011001;
      3'd5: seg = 7'b0010010;
      3'd6: seg = 7'b0000010;
      3'd7: seg = 7'b1111000;
      default: seg = 7'b1111111;
    endcase
  end

endmodule

// File: rtl/tug_of_war_field.sv
// Tug-of-war playfield: press pulses pull a lit position toward either goal,
// scoring rounds until one player reaches MAX_SCORE.
//
// state | meaning
// PLAY  | round in progress, leds show one-hot position
// P1WIN | single-cycle player1 round win, leds dark
// P2WIN | single-cycle player2 round win, leds dark
// DONE  | match over, winner held until reset
module tug_of_war_field
  import tow_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic [1:0]          press,
  output logic [NUM_LEDS-1:0] leds,
  output logic [6:0]          hex1,
  output logic [6:0]          hex2,
  output logic [1:0]          winner
);

  state_t     state, state_nxt;
  logic [3:0] pos, pos_nxt;
  logic [2:0] score1, score1_nxt;
  logic [2:0] score2, score2_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= PLAY;
      pos    <= CENTER;
      score1 <= 3'd0;
      score2 <= 3'd0;
    end else begin
      state  <= state_nxt;
      pos    <= pos_nxt;
      score1 <= score1_nxt;
      score2 <= score2_nxt;
    end
  end

  // Pulling past a goal end scores the round; pos is recentred on leaving PxWIN.
  always_comb begin
    state_nxt  = state;
    pos_nxt    = pos;
    score1_nxt = score1;
    score2_nxt = score2;
    case (state)
      PLAY: begin
        if (press == 2'b10) begin
          if (pos < POS_MAX) begin
            pos_nxt = pos + 4'd1;
          end else begin
            state_nxt = P1WIN;
            if (score1 < MAX_SCORE) score1_nxt = score1 + 3'd1;
          end
        end else if (press == 2'b01) begin
          if (pos > 4'd0) begin
            pos_nxt = pos - 4'd1;
          end else begin
            state_nxt = P2WIN;
            if (score2 < MAX_SCORE) score2_nxt = score2 + 3'd1;
          end
        end
      end
      P1WIN: begin
        pos_nxt   = CENTER;
        state_nxt = (score1 < MAX_SCORE) ? PLAY : DONE;
      end
      P2WIN: begin
        pos_nxt   = CENTER;
        state_nxt = (score2 < MAX_SCORE) ? PLAY : DONE;
      end
      DONE: begin
        state_nxt = DONE;
      end
      default: begin
        state_nxt = PLAY;
        pos_nxt   = CENTER;
      end
    endcase
  end

  always_comb begin
    leds   = '0;
    winner = WIN_NONE;
    if (state == PLAY) begin
      for (int i = 0; i < NUM_LEDS; i++) begin
        leds[i] = (pos == 4'(i));
      end
    end
    if (state == DONE) begin
      winner = (score1 == MAX_SCORE) ? WIN_P1 : WIN_P2;
    end
  end

  score_seg7 u_seg1 (
    .score (score1),
    .seg   (hex1)
  );

  score_seg7 u_seg2 (
    .score (score2),
    .seg   (hex2)
  );

endmodule

// File: tb/tb_tug_of_war_field.sv
// Directed self-checking bench for tug_of_war_field.
module tb_tug_of_war_field;

  logic       clk;
  logic       reset;
  logic [1:0] press;
  logic [8:0] leds;
  logic [6:0] hex1;
  logic [6:0] hex2;
  logic [1:0] winner;

  int pass_cnt = 0;
  int fail_cnt = 0;
  int total    = 0;

  logic [6:0] seg_tab [0:7];
  logic [8:0] walk_up [0:3];
  logic [8:0] walk_dn [0:3];

  tug_of_war_field dut (
    .clk    (clk),
    .reset  (reset),
    .press  (press),
    .leds   (leds),
    .hex1   (hex1),
    .hex2   (hex2),
    .winner (winner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input logic [1:0] p, input logic r);
    @(negedge clk);
    press = p;
    reset = r;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    seg_tab[0] = 7'b1000000; seg_tab[1] = 7'b1111001;
    seg_tab[2] = 7'b0100100; seg_tab[3] = 7'b0110000;
    seg_tab[4] = 7'b0011001; seg_tab[5] = 7'b0010010;
    seg_tab[6] = 7'b0000010; seg_tab[7] = 7'b1111000;
    walk_up[0] = 9'b000100000; walk_up[1] = 9'b001000000;
    walk_up[2] = 9'b010000000; walk_up[3] = 9'b100000000;
    walk_dn[0] = 9'b000001000; walk_dn[1] = 9'b000000100;
    walk_dn[2] = 9'b000000010; walk_dn[3] = 9'b000000001;

    press = 2'b00;
    reset = 1'b1;
    step(2'b00, 1'b1);
    step(2'b00, 1'b1);
    chk("reset_leds", 16'(leds), 16'h010);
    chk("reset_winner", 16'(winner), 16'h0);
    chk("reset_hex1", 16'(hex1), 16'(7'b1000000));
    chk("reset_hex2", 16'(hex2), 16'(7'b1000000));

    // player1 walks the light to its goal end
    for (int i = 0; i < 4; i++) begin
      step(2'b10, 1'b0);
      chk($sformatf("walk_up_%0d", i), 16'(leds), 16'(walk_up[i]));
    end

    step(2'b10, 1'b0);
    chk("p1win_leds", 16'(leds), 16'h0);
    chk("p1win_hex1", 16'(hex1), 16'(7'b1111001));
    chk("p1win_winner", 16'(winner), 16'h0);
    step(2'b10, 1'b0);
    chk("p1win_press_ignored", 16'(leds), 16'h010);

    for (int i = 0; i < 3; i++) begin
      step(2'b11, 1'b0);
      chk($sformatf("both_leds_%0d", i), 16'(leds), 16'h010);
    end
    chk("both_hex1", 16'(hex1), 16'(7'b1111001));
    chk("both_hex2", 16'(hex2), 16'(7'b1000000));

    step(2'b00, 1'b0);
    chk("idle_leds", 16'(leds), 16'h010);
    step(2'b10, 1'b0);
    step(2'b10, 1'b0);
    chk("pos6_leds", 16'(leds), 16'(9'b001000000));
    step(2'b10, 1'b1);
    chk("midreset_leds", 16'(leds), 16'h010);
    chk("midreset_hex1", 16'(hex1), 16'(7'b1000000));
    chk("midreset_hex2", 16'(hex2), 16'(7'b1000000));

    // player2 takes seven rounds
    for (int r = 0; r < 7; r++) begin
      for (int i = 0; i < 4; i++) begin
        step(2'b01, 1'b0);
        if (r == 0) chk($sformatf("walk_dn_%0d", i), 16'(leds), 16'(walk_dn[i]));
      end
      chk($sformatf("r%0d_at_goal", r), 16'(leds), 16'h001);
      step(2'b01, 1'b0);
      chk($sformatf("r%0d_p2win_leds", r), 16'(leds), 16'h0);
      chk($sformatf("r%0d_p2win_hex2", r), 16'(hex2), 16'(seg_tab[r+1]));
      chk($sformatf("r%0d_p2win_winner", r), 16'(winner), 16'h0);
      step(2'b00, 1'b0);
      if (r < 6) begin
        chk($sformatf("r%0d_recentre", r), 16'(leds), 16'h010);
        chk($sformatf("r%0d_winner", r), 16'(winner), 16'h0);
      end
    end
    chk("done_winner", 16'(winner), 16'(2'b01));
    chk("done_leds", 16'(leds), 16'h0);
    chk("done_hex2", 16'(hex2), 16'(7'b1111000));
    chk("done_hex1", 16'(hex1), 16'(7'b1000000));

    step(2'b10, 1'b0);
    step(2'b01, 1'b0);
    step(2'b11, 1'b0);
    chk("done_hold_winner", 16'(winner), 16'(2'b01));
    chk("done_hold_leds", 16'(leds), 16'h0);
    chk("done_hold_hex2", 16'(hex2), 16'(7'b1111000));

    step(2'b10, 1'b1);
    chk("done_reset_leds", 16'(leds), 16'h010);
    chk("done_reset_winner", 16'(winner), 16'h0);
    chk("done_reset_hex2", 16'(hex2), 16'(7'b1000000));
    step(2'b10, 1'b0);
    chk("after_reset_play", 16'(leds), 16'(9'b000100000));

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
